// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with mid-bit sampling behind a two-flop synchroniser.
// Good characters present a byte with a one-cycle we; a low stop bit pulses frame_err instead.
module uart_byte_rx #(
   parameter int CLKS_PER_BIT = 234,
   parameter int H            = CLKS_PER_BIT / 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       we,
   output logic       frame_err,
   output logic       busy
);
   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

   state_t        state_q, state_d;
   logic          rx_meta_q, rx_meta_d;
   logic          rx_s_q, rx_s_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    sh_q, sh_d;
   logic [7:0]    data_q, data_d;
   logic          we_q, we_d;
   logic          ferr_q, ferr_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         cnt_q     <= '0;
         idx_q     <= '0;
         sh_q      <= '0;
         data_q    <= '0;
         we_q      <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_meta_q <= rx_meta_d;
         rx_s_q    <= rx_s_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         sh_q      <= sh_d;
         data_q    <= data_d;
         we_q      <= we_d;
         ferr_q    <= ferr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rx_meta_d = rx;
      rx_s_d    = rx_meta_q;
      cnt_d     = cnt_q + CW'(1);
      idx_d     = idx_q;
      sh_d      = sh_q;
      data_d    = data_q;
      we_d      = 1'b0;
      ferr_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s_q) state_d = START;
         end
         START: begin
            // A start bit still low at its midpoint is genuine; otherwise it was a glitch.
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               idx_d = '0;
               state_d = rx_s_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               sh_d  = {rx_s_q, sh_q[7:1]};
               if (idx_q == 3'd7) state_d = STOP;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  data_d  = sh_q;
                  we_d    = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BRK;
               end
            end
         end
         BRK: begin
            // Hold off until the line is released so a held-low line cannot retrigger.
            cnt_d = '0;
            if (rx_s_q) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign data      = data_q;
   assign we        = we_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != IDLE);
endmodule
